// File: rtl/audio_frame_buffer_if.sv
// Producer-side handshake bundle for audio_frame_buffer: one stereo sample per
// accepted in_valid/in_ready transfer.
interface audio_frame_buffer_if #(
  parameter int CHANNEL_WIDTH = 16
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNEL_WIDTH-1:0] in_l;
  logic [CHANNEL_WIDTH-1:0] in_r;

  modport master (output in_valid, output in_l, output in_r, input in_ready);
  modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/audio_frame_buffer.sv
// Stereo sample FIFO feeding an I2S serializer: primes to PRIME_LEVEL entries,
// then releases one sample per rising edge of the serializer word-select.
module audio_frame_buffer #(
  parameter int CHANNEL_WIDTH = 16,
  parameter int DEPTH         = 8,
  parameter int PRIME_LEVEL   = DEPTH / 2
) (
  input  logic                       audio_sclk,
  input  logic                       reset_n,
  audio_frame_buffer_if.slave        in_bus,
  input  logic                       audio_lrck,
  input  logic                       mute,
  output logic [CHANNEL_WIDTH-1:0]   audio_l,
  output logic [CHANNEL_WIDTH-1:0]   audio_r,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [7:0]                 underflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 2 * CHANNEL_WIDTH;

  localparam logic [0:0] ST_PRIMING = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  logic [0:0]               state_r;
  logic [0:0]               state_nxt_s;
  logic                     lrck_q_r;
  logic [AW-1:0]            wr_ptr_r;
  logic [AW-1:0]            rd_ptr_r;
  logic [CW-1:0]            count_r;
  logic [CW-1:0]            count_nxt_s;
  logic [7:0]               underflow_cnt_r;
  logic [CHANNEL_WIDTH-1:0] audio_l_r;
  logic [CHANNEL_WIDTH-1:0] audio_r_r;
  logic [SW-1:0]            mem_r [DEPTH];

  logic                     frame_tick_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     underflow_s;
  logic                     load_s;
  logic [CHANNEL_WIDTH-1:0] load_l_s;
  logic [CHANNEL_WIDTH-1:0] load_r_s;
  logic [SW-1:0]            head_s;

  assign frame_tick_s    = audio_lrck & ~lrck_q_r;
  assign in_bus.in_ready = (count_r != CW'(DEPTH));
  assign push_s          = in_bus.in_valid & in_bus.in_ready;
  assign head_s          = mem_r[rd_ptr_r];

  assign audio_l         = audio_l_r;
  assign audio_r         = audio_r_r;
  assign fill_level      = count_r;
  assign underflow_count = underflow_cnt_r;

  // Pop/underflow decisions and next state, all keyed off the word-select tick.
  always_comb begin
    pop_s       = 1'b0;
    underflow_s = 1'b0;
    load_s      = 1'b0;
    load_l_s    = {CHANNEL_WIDTH{1'b0}};
    load_r_s    = {CHANNEL_WIDTH{1'b0}};
    state_nxt_s = state_r;
    case (state_r)
      ST_PRIMING: begin
        if (frame_tick_s) begin
          load_s = 1'b1;
          if (count_r >= CW'(PRIME_LEVEL)) begin
            state_nxt_s = ST_RUNNING;
          end else begin
            state_nxt_s = ST_PRIMING;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (frame_tick_s && (count_r != {CW{1'b0}})) begin
          pop_s  = 1'b1;
          load_s = 1'b1;
          if (mute) begin
            load_l_s = {CHANNEL_WIDTH{1'b0}};
            load_r_s = {CHANNEL_WIDTH{1'b0}};
          end else begin
            load_l_s = head_s[SW-1:CHANNEL_WIDTH];
            load_r_s = head_s[CHANNEL_WIDTH-1:0];
          end
        end else if (frame_tick_s) begin
          underflow_s = 1'b1;
          state_nxt_s = ST_PRIMING;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_PRIMING;
      end
    endcase
  end

  // Occupancy: a write and a pop in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge audio_sclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_bus.in_l, in_bus.in_r};
    end
  end

  // Control state, pointers, counters and the registered output samples.
  always_ff @(posedge audio_sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_PRIMING;
      lrck_q_r        <= 1'b0;
      wr_ptr_r        <= {AW{1'b0}};
      rd_ptr_r        <= {AW{1'b0}};
      count_r         <= {CW{1'b0}};
      underflow_cnt_r <= 8'd0;
      audio_l_r       <= {CHANNEL_WIDTH{1'b0}};
      audio_r_r       <= {CHANNEL_WIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      lrck_q_r <= audio_lrck;
      count_r  <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (load_s) begin
        audio_l_r <= load_l_s;
        audio_r_r <= load_r_s;
      end
      if (underflow_s && (underflow_cnt_r != 8'hFF)) begin
        underflow_cnt_r <= underflow_cnt_r + 8'd1;
      end
    end
  end
endmodule
